stack_param: RTL
================

// Module: stack_param
// PURPOSE
//  Parametrised LIFO stack; successor to the fixed 5x4-bit stack. Separate in/out data buses,
//  registered output with valid strobe, occupancy count, full/empty flags, error strobe and a
//  selectable overflow policy. Sits between a command source (CPU/test sequencer) and a consumer.
// PARAMETERS
//  WIDTH      4  data word width in bits (>=1)
//  DEPTH      5  number of entries (>=2; need not be a power of two)
//  OVERWRITE  1  1: push when full discards oldest entry (circular); 0: push when full rejected
//  IW         $clog2(DEPTH)    derived: INDEX width
//  CW         $clog2(DEPTH+1)  derived: COUNT width
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RESET      in   1      asynchronous, active-low reset
//  COMMAND    in   3      000 NOP, 001 PUSH, 010 POP, 011 GET, 100 CLEAR, 101 REPLACE, 11x NOP
//  INDEX      in   IW     GET depth: 0 = top, 1 = one below top, ...
//  DATA_IN    in   WIDTH  word for PUSH/REPLACE, sampled at the command edge
//  DATA_OUT   out  WIDTH  result of POP/GET/REPLACE, registered
//  OUT_VALID  out  1      one-cycle strobe: DATA_OUT updated this cycle
//  ERR        out  1      one-cycle strobe: command rejected (see below)
//  COUNT      out  CW     entries held, 0..DEPTH
//  EMPTY      out  1      COUNT == 0 (combinational from COUNT)
//  FULL       out  1      COUNT == DEPTH (combinational from COUNT)
// BEHAVIOUR
//  - Storage: DEPTH x WIDTH regs, circular; top pointer TOP in 0..DEPTH-1, wraps DEPTH-1 -> 0.
//  - RESET low: immediately TOP=0, COUNT=0, all entries 0, DATA_OUT=0, OUT_VALID=0, ERR=0;
//    held while low; resumes on first CLK edge after deassertion. Aborts any command in flight.
//  - One command per cycle; effects visible the cycle after the edge (latency 1); OUT_VALID and
//    ERR are high for exactly one cycle per command, never both.
//  - NOP: no state change; OUT_VALID=0, ERR=0; DATA_OUT holds last value.
//  - PUSH, not full: TOP=TOP+1 mod DEPTH, entry[TOP]=DATA_IN, COUNT+1.
//  - PUSH, full, OVERWRITE=1: as above, oldest entry lost, COUNT stays DEPTH, ERR=0.
//  - PUSH, full, OVERWRITE=0: no state change, ERR=1.
//  - POP, not empty: DATA_OUT=entry[TOP], OUT_VALID=1, TOP=TOP-1 mod DEPTH, COUNT-1.
//    Popped entry is not cleared.
//  - POP, empty: no state change, DATA_OUT holds, ERR=1.
//  - GET: if INDEX < COUNT: DATA_OUT=entry[(TOP-INDEX) mod DEPTH], OUT_VALID=1, no state change;
//    else (incl. INDEX >= DEPTH, or empty) ERR=1, DATA_OUT holds.
//  - CLEAR: COUNT=0, TOP=0; entries, DATA_OUT unchanged; no strobe.
//  - REPLACE, not empty: DATA_OUT=old entry[TOP], OUT_VALID=1, entry[TOP]=DATA_IN; TOP, COUNT
//    unchanged (atomic pop+push). REPLACE, empty: acts as PUSH, OUT_VALID=0, ERR=0.
//  - Modulo arithmetic must be correct for non-power-of-two DEPTH (explicit compare-and-wrap,
//    no bit truncation). COUNT saturates at DEPTH and never underflows.
//  - Reserved codes 11x behave as NOP.
// TESTING
//  1 Reset: RESET low mid-PUSH -> COUNT=0, EMPTY=1, DATA_OUT=0, no strobes; later POP -> ERR=1.
//  2 DEPTH=5: PUSH 1,2,3 then GET 0,1,2,3 -> DATA_OUT 3,2,1 with OUT_VALID; INDEX=3 -> ERR=1.
//  3 OVERWRITE=1, DEPTH=5: PUSH 1..7 -> FULL=1, COUNT=5; POP x5 -> 7,6,5,4,3; 6th POP -> ERR.
//  4 OVERWRITE=0: PUSH 1..6 -> 6th push ERR=1, COUNT=5; POP -> 5.
//  5 PUSH 9, REPLACE 4 -> DATA_OUT=9, COUNT=1; POP -> 4; CLEAR after PUSH 1,2 -> EMPTY=1.
//  6 DEPTH=3, WIDTH=8: 10 random PUSH/POP/GET vs reference model; pointer wrap past 2 -> 0 exact.

Source files
------------

// File: rtl/stack_param_if.sv
// Command/result bus between a stack client and the stack_param LIFO.
// Latency: none, this is only a signal bundle.
// Backpressure: none; the client issues one command per cycle and reads results a cycle later.
interface stack_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]       command;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             err;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  // Command source side
  modport master (
    output command, index, data_in,
    input  data_out, out_valid, err, count, empty, full
  );

  // Stack side
  modport slave (
    input  command, index, data_in,
    output data_out, out_valid, err, count, empty, full
  );
endinterface

// File: rtl/stack_param.sv
// Parametrised circular LIFO stack with push/pop/get/clear/replace and selectable overflow policy.
// Latency: 1 cycle from command edge to data_out/out_valid/err/count.
// Backpressure: none; illegal commands (pop empty, bad get, push full without overwrite) pulse err.
module stack_param #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 5,
  parameter int OVERWRITE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_param_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] CMD_PUSH    = 3'b001;
  localparam logic [2:0] CMD_POP     = 3'b010;
  localparam logic [2:0] CMD_GET     = 3'b011;
  localparam logic [2:0] CMD_CLEAR   = 3'b100;
  localparam logic [2:0] CMD_REPLACE = 3'b101;

  localparam logic [IW-1:0] TOP_MAX = IW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [IW:0]   DEP_X   = (IW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [IW-1:0]    top, top_nxt, top_inc, top_dec, get_addr;
  logic [IW:0]      get_sum;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] dout, dout_nxt;
  logic             vld, vld_nxt, err, err_nxt;
  logic             is_empty, is_full, idx_ok;

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_MAX);
  assign idx_ok   = (CW'(bus.index) < count);

  // Pointer neighbours and GET address, wrapped by explicit compare so any DEPTH works
  always_comb begin
    top_inc = (top == TOP_MAX) ? '0 : top + 1'b1;
    top_dec = (top == '0) ? TOP_MAX : top - 1'b1;
    get_sum = {1'b0, top} + DEP_X - {1'b0, bus.index};
    if (get_sum >= DEP_X) get_addr = IW'(get_sum - DEP_X);
    else                  get_addr = IW'(get_sum);
  end

  // Command decode: next storage, pointer, count and result strobes
  always_comb begin
    mem_nxt   = mem;
    top_nxt   = top;
    count_nxt = count;
    dout_nxt  = dout;
    vld_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (bus.command)
      CMD_PUSH: begin
        if (!is_full || OVERWRITE != 0) begin
          // When full with overwrite, advancing top lands on the oldest entry
          top_nxt          = top_inc;
          mem_nxt[top_inc] = bus.data_in;
          if (!is_full) count_nxt = count + 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      CMD_POP: begin
        if (!is_empty) begin
          dout_nxt  = mem[top];
          vld_nxt   = 1'b1;
          top_nxt   = top_dec;
          count_nxt = count - 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      CMD_GET: begin
        if (idx_ok) begin
          dout_nxt = mem[get_addr];
          vld_nxt  = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end
      CMD_CLEAR: begin
        top_nxt   = '0;
        count_nxt = '0;
      end
      CMD_REPLACE: begin
        if (!is_empty) begin
          dout_nxt      = mem[top];
          vld_nxt       = 1'b1;
          mem_nxt[top]  = bus.data_in;
        end else begin
          // Empty stack: behaves as a plain push, which can never overflow here
          top_nxt          = top_inc;
          mem_nxt[top_inc] = bus.data_in;
          count_nxt        = count + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State registers; reset clears storage and aborts the command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      top   <= '0;
      count <= '0;
      dout  <= '0;
      vld   <= 1'b0;
      err   <= 1'b0;
    end else begin
      mem   <= mem_nxt;
      top   <= top_nxt;
      count <= count_nxt;
      dout  <= dout_nxt;
      vld   <= vld_nxt;
      err   <= err_nxt;
    end
  end

  assign bus.data_out  = dout;
  assign bus.out_valid = vld;
  assign bus.err       = err;
  assign bus.count     = count;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
endmodule
